conv_scheduler: RTL

CONV_SCHEDULER -- requirements
Module: conv_scheduler

---
 rtl/conv_scheduler_if.sv | 31 +++
 rtl/conv_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/conv_scheduler_if.sv
// Bus between the convolution scheduler and its rj/coefficient/data memories
// and MAC datapath. The scheduler takes the slave side.
interface conv_scheduler_if;
  logic        rj_load;
  logic        sample_valid;
  logic [7:0]  cur_addr;
  logic [15:0] rj_data;
  logic [15:0] coeff_data;
  logic [3:0]  rj_rd_addr;
  logic [8:0]  coeff_addr;
  logic [7:0]  data_addr;
  logic [1:0]  mac_op;
  logic        acc_clear;
  logic        result_valid;
  logic        busy;
  logic        cfg_valid;
  logic        cfg_err;
  logic        overrun;

  modport master (
    output rj_load, sample_valid, cur_addr, rj_data, coeff_data,
    input  rj_rd_addr, coeff_addr, data_addr, mac_op, acc_clear,
           result_valid, busy, cfg_valid, cfg_err, overrun
  );

  modport slave (
    input  rj_load, sample_valid, cur_addr, rj_data, coeff_data,
    output rj_rd_addr, coeff_addr, data_addr, mac_op, acc_clear,
           result_valid, busy, cfg_valid, cfg_err, overrun
  );
endinterface

// File: rtl/conv_scheduler.sv
// Convolution scheduler: loads the per-group tap counts (rj), then for each
// accepted sample walks the coefficient table and streams MAC operations.
module conv_scheduler (
  input logic             SCLK,
  input logic             Reset_n,
  conv_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RJ_FETCH, RUN, DRAIN} state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  state_t      state;
  logic [9:0]  rj [16];
  logic [4:0]  fetch_cnt;
  logic [13:0] rj_sum;
  logic        rj_bad;
  logic [7:0]  base;
  logic [3:0]  grp;
  logic [9:0]  left;
  logic [8:0]  addr_cnt;
  logic        rd_now, sh_now, last_now;
  logic        rd1, sh1, rd2, sh2, sign2;
  logic [1:0]  drain_cnt;

  logic [13:0] sum_next;
  logic        bad_next, cfg_ok, accept, do_sched;
  logic [3:0]  pick_grp, grp_inc;
  logic [9:0]  pick_left;
  logic [8:0]  pick_addr;
  logic        sch_rd, sch_last;
  logic [3:0]  sch_grp;
  logic [9:0]  sch_left;
  logic        unused_coeff_bits;

  assign unused_coeff_bits = &{1'b0, bus.coeff_data[15:9]};

  assign sum_next = rj_sum + {4'd0, bus.rj_data[9:0]};
  assign bad_next = rj_bad | (|bus.rj_data[15:10]);
  assign cfg_ok   = !bad_next && (sum_next <= 14'd512);
  assign accept   = (state == IDLE) && bus.sample_valid && bus.cfg_valid && !bus.rj_load;
  assign do_sched = accept || ((state == RUN) && !last_now);

  // The first slot of a run is scheduled from group 0 while still in IDLE.
  assign pick_grp  = (state == RUN) ? grp : 4'd0;
  assign pick_left = (state == RUN) ? left : rj[0];
  assign pick_addr = (state == RUN) ? addr_cnt : 9'd0;
  assign grp_inc   = pick_grp + 4'd1;

  always_comb begin
    sch_rd   = (pick_left != 10'd0);
    sch_last = !sch_rd && (pick_grp == 4'd15);
    sch_grp  = pick_grp;
    sch_left = pick_left;
    if (sch_rd) begin
      sch_left = pick_left - 10'd1;
    end else if (!sch_last) begin
      sch_grp  = grp_inc;
      sch_left = rj[grp_inc];
    end
  end

  always_ff @(posedge SCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      for (int i = 0; i < 16; i++) rj[i] <= '0;
      fetch_cnt <= '0;
      rj_sum    <= '0;
      rj_bad    <= 1'b0;
      base      <= '0;
      grp       <= '0;
      left      <= '0;
      addr_cnt  <= '0;
      rd_now    <= 1'b0;
      sh_now    <= 1'b0;
      last_now  <= 1'b0;
      rd1       <= 1'b0;
      sh1       <= 1'b0;
      rd2       <= 1'b0;
      sh2       <= 1'b0;
      sign2     <= 1'b0;
      drain_cnt <= '0;
      bus.rj_rd_addr   <= '0;
      bus.coeff_addr   <= '0;
      bus.data_addr    <= '0;
      bus.mac_op       <= OP_NOP;
      bus.acc_clear    <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.cfg_valid    <= 1'b0;
      bus.cfg_err      <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.acc_clear    <= 1'b0;
      bus.result_valid <= 1'b0;
      rd_now <= 1'b0;
      sh_now <= 1'b0;

      // Three-stage token pipeline: read slot -> data_addr -> mac_op.
      rd1   <= rd_now;
      sh1   <= sh_now;
      rd2   <= rd1;
      sh2   <= sh1;
      sign2 <= bus.coeff_data[8];
      if (rd1) bus.data_addr <= base - bus.coeff_data[7:0];
      if (rd2)      bus.mac_op <= sign2 ? OP_SUB : OP_ADD;
      else if (sh2) bus.mac_op <= OP_SHIFT;
      else          bus.mac_op <= OP_NOP;

      if (bus.sample_valid && ((state != IDLE) || bus.rj_load)) bus.overrun <= 1'b1;
      if (bus.rj_load && (state != IDLE)) bus.cfg_err <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.rj_load) begin
            state          <= RJ_FETCH;
            bus.busy       <= 1'b1;
            bus.cfg_valid  <= 1'b0;
            bus.cfg_err    <= 1'b0;
            bus.rj_rd_addr <= '0;
            fetch_cnt      <= '0;
            rj_sum         <= '0;
            rj_bad         <= 1'b0;
          end else if (accept) begin
            state         <= RUN;
            bus.busy      <= 1'b1;
            bus.acc_clear <= 1'b1;
            base          <= bus.cur_addr;
          end
        end
        RJ_FETCH: begin
          fetch_cnt <= fetch_cnt + 5'd1;
          if (fetch_cnt != 5'd0) begin
            rj[fetch_cnt[3:0] - 4'd1] <= bus.rj_data[9:0];
            rj_sum <= sum_next;
            rj_bad <= bad_next;
          end
          if (fetch_cnt < 5'd15) bus.rj_rd_addr <= bus.rj_rd_addr + 4'd1;
          if (fetch_cnt == 5'd16) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.cfg_valid <= cfg_ok;
            bus.cfg_err   <= bus.cfg_err | bus.rj_load | !cfg_ok;
          end
        end
        RUN: begin
          if (last_now) begin
            state     <= DRAIN;
            last_now  <= 1'b0;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd2) begin
            state            <= IDLE;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Decide what the next cycle carries: a coefficient read or a group SHIFT.
      if (do_sched) begin
        rd_now   <= sch_rd;
        sh_now   <= !sch_rd;
        last_now <= sch_last;
        grp      <= sch_grp;
        left     <= sch_left;
        if (sch_rd) begin
          bus.coeff_addr <= pick_addr;
          addr_cnt       <= pick_addr + 9'd1;
        end
      end
    end
  end

endmodule
